// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared state encoding and counter-width helpers for the button debouncer
package button_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HELD      = 2'd1,
    REPEATING = 2'd2
  } hold_state_t;

  function automatic int debounce_width(input int stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

  function automatic int hold_width(input int repeat_delay, input int repeat_period);
    return $clog2(((repeat_delay > repeat_period) ? repeat_delay : repeat_period) + 1);
  endfunction

endpackage

// File: rtl/button_debounce_channel.sv
// rtl/button_debounce_channel.sv - one channel: synchroniser, debounce counter and press/repeat FSM
module button_debounce_channel
  import button_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 65536,
  parameter int REPEAT_DELAY  = 30000000,
  parameter int REPEAT_PERIOD = 7500000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  input  logic repeat_en,
  output logic level,
  output logic press,
  output logic released,
  output logic held
);

  localparam int DW = debounce_width(STABLE_CYCLES);
  localparam int HW = hold_width(REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [DW-1:0] DEB_LAST    = DW'(STABLE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_ONE     = DW'(1);
  localparam logic [HW-1:0] DELAY_LAST  = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD - 1);
  localparam logic [HW-1:0] HOLD_ONE    = HW'(1);
  localparam logic [HW-1:0] HOLD_MAX    = '1;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [DW-1:0]          deb_cnt, deb_next;
  logic                   level_next, rise, fall;
  hold_state_t            state, state_next;
  logic [HW-1:0]          hold_cnt, hold_next, hold_inc;
  logic                   fire;
  logic                   press_next, released_next, held_next;

  assign s        = sync[SYNC_STAGES-1];
  assign hold_inc = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + HOLD_ONE;

  always_comb begin
    deb_next   = deb_cnt;
    level_next = level;
    if (s == level) begin
      deb_next = '0;
    end else if (deb_cnt == DEB_LAST) begin
      deb_next   = '0;
      level_next = ~level;
    end else begin
      deb_next = deb_cnt + DEB_ONE;
    end
  end

  // Edges are taken from the level being written so press/release land in the same cycle as the new level.
  assign rise = level_next & ~level;
  assign fall = ~level_next & level;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync     <= '0;
      deb_cnt  <= '0;
      level    <= 1'b0;
      state    <= IDLE;
      hold_cnt <= '0;
      press    <= 1'b0;
      released <= 1'b0;
      held     <= 1'b0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], raw};
      deb_cnt  <= deb_next;
      level    <= level_next;
      state    <= state_next;
      hold_cnt <= hold_next;
      press    <= press_next;
      released <= released_next;
      held     <= held_next;
    end
  end

  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    fire       = 1'b0;
    if (fall) begin
      state_next = IDLE;
      hold_next  = '0;
    end else if (rise) begin
      state_next = HELD;
      hold_next  = '0;
    end else begin
      case (state)
        IDLE: hold_next = '0;
        HELD: begin
          if (!repeat_en) begin
            hold_next = '0;
          end else if (hold_cnt == DELAY_LAST) begin
            fire       = 1'b1;
            hold_next  = '0;
            state_next = REPEATING;
          end else begin
            hold_next = hold_inc;
          end
        end
        REPEATING: begin
          if (!repeat_en) begin
            state_next = HELD;
            hold_next  = '0;
          end else if (hold_cnt == PERIOD_LAST) begin
            fire      = 1'b1;
            hold_next = '0;
          end else begin
            hold_next = hold_inc;
          end
        end
        default: begin
          state_next = IDLE;
          hold_next  = '0;
        end
      endcase
    end
  end

  // A fall takes priority above, so a repeat due in the release cycle is dropped.
  always_comb begin
    press_next    = rise | fire;
    released_next = fall;
    held_next     = (state_next == REPEATING);
  end

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - N-channel button conditioner built from independent channel instances
module button_debouncer #(
  parameter int CHANNELS      = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 65536,
  parameter int REPEAT_DELAY  = 30000000,
  parameter int REPEAT_PERIOD = 7500000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] io_in,
  input  logic [CHANNELS-1:0] io_repeatEn,
  output logic [CHANNELS-1:0] io_level,
  output logic [CHANNELS-1:0] io_press,
  output logic [CHANNELS-1:0] io_release,
  output logic [CHANNELS-1:0] io_held
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    button_debounce_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clock    (clock),
      .reset    (reset),
      .raw      (io_in[i]),
      .repeat_en(io_repeatEn[i]),
      .level    (io_level[i]),
      .press    (io_press[i]),
      .released (io_release[i]),
      .held     (io_held[i])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - directed scoreboard bench for button_debouncer
module tb_button_debouncer;

  localparam int LVL = 0;
  localparam int PRS = 1;
  localparam int REL = 2;
  localparam int HLD = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] io_in = 4'b0;
  logic [3:0] io_repeatEn = 4'b0;
  logic [3:0] io_level, io_press, io_release, io_held;

  button_debouncer #(
    .CHANNELS     (4),
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(4),
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(5)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .io_in      (io_in),
    .io_repeatEn(io_repeatEn),
    .io_level   (io_level),
    .io_press   (io_press),
    .io_release (io_release),
    .io_held    (io_held)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         at;
    string      tag;
    int         sel;
    logic [3:0] mask;
    logic [3:0] val;
  } exp_t;

  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;

  function automatic logic [3:0] pick(input int sel);
    case (sel)
      LVL:     return io_level;
      PRS:     return io_press;
      REL:     return io_release;
      default: return io_held;
    endcase
  endfunction

  task automatic expect_at(input int at, input string tag, input int sel,
                           input logic [3:0] mask, input logic [3:0] val);
    exp_t e;
    e.at = at; e.tag = tag; e.sel = sel; e.mask = mask; e.val = val;
    sb.push_back(e);
  endtask

  task automatic check_due();
    for (int i = sb.size() - 1; i >= 0; i--) begin
      exp_t e;
      logic [3:0] got;
      e = sb[i];
      if (e.at <= cyc) begin
        got = pick(e.sel) & e.mask;
        compared++;
        assert (e.at == cyc && got === (e.val & e.mask)) else begin
          mismatched++;
          $error("FAIL %s @%0d (now %0d): observed %b expected %b", e.tag, e.at, cyc, got, e.val & e.mask);
        end
        sb.delete(i);
      end
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      @(negedge clock);
      check_due();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, t, e;
    repeat (2) @(negedge clock);
    expect_at(cyc, "reset_level", LVL, 4'hF, 4'h0);
    expect_at(cyc, "reset_press", PRS, 4'hF, 4'h0);
    expect_at(cyc, "reset_release", REL, 4'hF, 4'h0);
    expect_at(cyc, "reset_held", HLD, 4'hF, 4'h0);
    check_due();
    reset = 1'b0;
    step(2);

    // clean press on channel 0
    c = cyc;
    io_in[0] = 1'b1;
    expect_at(c + 5, "clean_level_pre", LVL, 4'b0001, 4'b0000);
    expect_at(c + 6, "clean_level", LVL, 4'b0001, 4'b0001);
    expect_at(c + 5, "clean_press_pre", PRS, 4'b0001, 4'b0000);
    expect_at(c + 6, "clean_press", PRS, 4'b0001, 4'b0001);
    expect_at(c + 7, "clean_press_end", PRS, 4'b0001, 4'b0000);
    expect_at(c + 6, "clean_no_release", REL, 4'b0001, 4'b0000);
    step(8);

    // 3-cycle glitch on channel 1
    c = cyc;
    io_in[1] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      expect_at(c + k, "glitch_level", LVL, 4'b0010, 4'b0000);
      expect_at(c + k, "glitch_press", PRS, 4'b0010, 4'b0000);
    end
    step(3);
    io_in[1] = 1'b0;
    step(10);

    // bounce 1,0,1,1,1,1 on channel 1
    c = cyc;
    expect_at(c + 7, "bounce_level_pre", LVL, 4'b0010, 4'b0000);
    expect_at(c + 8, "bounce_level", LVL, 4'b0010, 4'b0010);
    expect_at(c + 8, "bounce_press", PRS, 4'b0010, 4'b0010);
    io_in[1] = 1'b1;
    step(1);
    io_in[1] = 1'b0;
    step(1);
    io_in[1] = 1'b1;
    step(8);

    // simultaneous release of channels 0 and 1
    c = cyc;
    io_in[1:0] = 2'b00;
    expect_at(c + 5, "rel01_pre", REL, 4'b0011, 4'b0000);
    expect_at(c + 6, "rel01", REL, 4'b0011, 4'b0011);
    expect_at(c + 7, "rel01_end", REL, 4'b0011, 4'b0000);
    expect_at(c + 6, "rel01_level", LVL, 4'b0011, 4'b0000);
    expect_at(c + 6, "rel01_no_press", PRS, 4'b0011, 4'b0000);
    step(8);

    // channels 0 and 3 pressed together
    c = cyc;
    io_in[0] = 1'b1;
    io_in[3] = 1'b1;
    expect_at(c + 5, "multi_press_pre", PRS, 4'hF, 4'b0000);
    expect_at(c + 6, "multi_press", PRS, 4'hF, 4'b1001);
    expect_at(c + 7, "multi_press_end", PRS, 4'hF, 4'b0000);
    expect_at(c + 6, "multi_level", LVL, 4'hF, 4'b1001);
    step(8);
    c = cyc;
    io_in = 4'b0000;
    expect_at(c + 6, "multi_release", REL, 4'hF, 4'b1001);
    expect_at(c + 6, "multi_level_off", LVL, 4'hF, 4'b0000);
    step(8);

    // auto-repeat on channel 2, released when a repeat is due
    io_repeatEn[2] = 1'b1;
    c = cyc;
    t = c + 6;
    io_in[2] = 1'b1;
    expect_at(t, "rep_press0", PRS, 4'b0100, 4'b0100);
    expect_at(t + 1, "rep_gap1", PRS, 4'b0100, 4'b0000);
    expect_at(t + 9, "rep_gap9", PRS, 4'b0100, 4'b0000);
    expect_at(t + 10, "rep_press10", PRS, 4'b0100, 4'b0100);
    expect_at(t + 14, "rep_gap14", PRS, 4'b0100, 4'b0000);
    expect_at(t + 15, "rep_press15", PRS, 4'b0100, 4'b0100);
    expect_at(t + 16, "rep_gap16", PRS, 4'b0100, 4'b0000);
    expect_at(t + 20, "rep_press20", PRS, 4'b0100, 4'b0100);
    expect_at(t + 24, "rep_gap24", PRS, 4'b0100, 4'b0000);
    expect_at(t + 25, "rep_press25", PRS, 4'b0100, 4'b0100);
    expect_at(t + 9, "rep_held_pre", HLD, 4'b0100, 4'b0000);
    expect_at(t + 10, "rep_held", HLD, 4'b0100, 4'b0100);
    step(30);
    io_in[2] = 1'b0;
    expect_at(t + 29, "rep_held_last", HLD, 4'b0100, 4'b0100);
    expect_at(t + 29, "rep_rel_pre", REL, 4'b0100, 4'b0000);
    expect_at(t + 30, "rep_rel", REL, 4'b0100, 4'b0100);
    expect_at(t + 31, "rep_rel_end", REL, 4'b0100, 4'b0000);
    expect_at(t + 30, "rep_rel_no_press", PRS, 4'b0100, 4'b0000);
    expect_at(t + 30, "rep_rel_held", HLD, 4'b0100, 4'b0000);
    expect_at(t + 30, "rep_rel_level", LVL, 4'b0100, 4'b0000);
    step(8);

    // dropping repeat enable mid-REPEATING, then re-arming
    c = cyc;
    t = c + 6;
    io_in[2] = 1'b1;
    expect_at(t, "dis_press0", PRS, 4'b0100, 4'b0100);
    expect_at(t + 10, "dis_press10", PRS, 4'b0100, 4'b0100);
    expect_at(t + 15, "dis_press15", PRS, 4'b0100, 4'b0100);
    expect_at(t + 17, "dis_held_on", HLD, 4'b0100, 4'b0100);
    step(23);
    io_repeatEn[2] = 1'b0;
    expect_at(t + 18, "dis_held_off", HLD, 4'b0100, 4'b0000);
    for (int k = 18; k <= 30; k++) expect_at(t + k, "dis_no_press", PRS, 4'b0100, 4'b0000);
    step(14);
    e = cyc;
    io_repeatEn[2] = 1'b1;
    expect_at(e + 9, "rearm_held_pre", HLD, 4'b0100, 4'b0000);
    expect_at(e + 10, "rearm_held", HLD, 4'b0100, 4'b0100);
    expect_at(e + 10, "rearm_press", PRS, 4'b0100, 4'b0100);
    step(12);

    // async reset between edges while REPEATING with input still held
    c = cyc;
    #1 reset = 1'b1;
    #1;
    expect_at(cyc, "areset_level", LVL, 4'hF, 4'h0);
    expect_at(cyc, "areset_press", PRS, 4'hF, 4'h0);
    expect_at(cyc, "areset_release", REL, 4'hF, 4'h0);
    expect_at(cyc, "areset_held", HLD, 4'hF, 4'h0);
    check_due();
    #1 reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      expect_at(c + k, "post_rst_level", LVL, 4'b0100, 4'b0000);
      expect_at(c + k, "post_rst_no_release", REL, 4'b0100, 4'b0000);
    end
    expect_at(c + 6, "post_rst_level_up", LVL, 4'b0100, 4'b0100);
    expect_at(c + 6, "post_rst_press", PRS, 4'b0100, 4'b0100);
    expect_at(c + 15, "post_rst_held_pre", HLD, 4'b0100, 4'b0000);
    expect_at(c + 16, "post_rst_held", HLD, 4'b0100, 4'b0100);
    step(18);

    step(2);
    compared++;
    assert (sb.size() == 0) else begin
      mismatched++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
